// File: rtl/hand_range_transmitter.sv
// Alternating left/right ultrasonic ranger driver with per-side gain strobes.
// Optional macro HAND_RANGE_AVG2_EN enables a two-sample running average per side.
module hand_range_transmitter #(
    parameter int unsigned TRIG_CYCLES  = 100,
    parameter int unsigned ECHO_TIMEOUT = 400000,
    parameter int unsigned GAP_CYCLES   = 600000,
    parameter int unsigned DIST_SHIFT   = 4,
    parameter logic [7:0]  DEFAULT_GAIN = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    output logic        leftTrig,
    input  logic        leftEcho,
    output logic        rightTrig,
    input  logic        rightEcho,
    input  logic        cfgWrite,
    input  logic        cfgSide,
    input  logic [7:0]  cfgGain,
    output logic        acceptLeftHandDistance,
    output logic [15:0] leftHandDistance,
    output logic        acceptRightHandDistance,
    output logic [15:0] rightHandDistance,
    output logic        acceptLeftHandGain,
    output logic [7:0]  leftHandGain,
    output logic        acceptRightHandGain,
    output logic [7:0]  rightHandGain
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] TRIG = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] MEAS = 3'd3;
    localparam logic [2:0] EMIT = 3'd4;
    localparam logic [2:0] GAP  = 3'd5;

    localparam logic [23:0] TRIG_LAST = 24'(TRIG_CYCLES - 1);
    localparam logic [23:0] WAIT_LAST = 24'(ECHO_TIMEOUT - 1);
    localparam logic [23:0] ECHO_MAX  = 24'(ECHO_TIMEOUT);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        side_q, side_d;
    logic [15:0] result_q, result_d;
    logic        echo;
    logic [23:0] shifted;
    logic [15:0] scaled;
    logic [15:0] emit_value;
    logic        emit_left, emit_right;

    assign echo       = side_q ? rightEcho : leftEcho;
    assign shifted    = cnt_q >> DIST_SHIFT;
    assign emit_left  = (state_q == EMIT) && !side_q;
    assign emit_right = (state_q == EMIT) && side_q;

    // A real echo that shifts to zero is reported as 1 so it never reads as "absent".
    always_comb begin
        if (shifted > 24'h00FFFF) begin
            scaled = 16'hFFFF;
        end else if (shifted == 24'd0) begin
            scaled = 16'd1;
        end else begin
            scaled = shifted[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        side_d   = side_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                state_d = TRIG;
                cnt_d   = 24'd0;
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT;
                    cnt_d   = 24'd0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            WAIT: begin
                if (echo) begin
                    // The cycle in which the rise is seen counts as the first high cycle.
                    state_d = MEAS;
                    cnt_d   = 24'd1;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d  = EMIT;
                    result_d = 16'd0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            MEAS: begin
                if (!echo) begin
                    state_d  = EMIT;
                    result_d = scaled;
                end else if (cnt_q == ECHO_MAX) begin
                    state_d  = EMIT;
                    result_d = 16'hFFFF;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            EMIT: begin
                state_d = GAP;
                cnt_d   = 24'd0;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = TRIG;
                    cnt_d   = 24'd0;
                    side_d  = ~side_q;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 24'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 24'd0;
            side_q   <= 1'b0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            side_q   <= side_d;
            result_q <= result_d;
        end
    end

`ifdef HAND_RANGE_AVG2_EN
    logic [15:0] hist_left, hist_right, hist_prev;

    assign hist_prev = side_q ? hist_right : hist_left;

    always_comb begin
        if ((hist_prev != 16'd0) && (result_q != 16'd0)) begin
            emit_value = 16'((17'(hist_prev) + 17'(result_q) + 17'd1) >> 1);
        end else begin
            emit_value = result_q;
        end
    end

    // History holds the raw previous result; a zero result clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_left  <= 16'd0;
            hist_right <= 16'd0;
        end else begin
            if (emit_left) begin
                hist_left <= result_q;
            end
            if (emit_right) begin
                hist_right <= result_q;
            end
        end
    end
`else
    assign emit_value = result_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leftTrig                <= 1'b0;
            rightTrig               <= 1'b0;
            acceptLeftHandDistance  <= 1'b0;
            acceptRightHandDistance <= 1'b0;
            leftHandDistance        <= 16'd0;
            rightHandDistance       <= 16'd0;
        end else begin
            leftTrig                <= (state_q == TRIG) && !side_q;
            rightTrig               <= (state_q == TRIG) && side_q;
            acceptLeftHandDistance  <= emit_left;
            acceptRightHandDistance <= emit_right;
            if (emit_left) begin
                leftHandDistance <= emit_value;
            end
            if (emit_right) begin
                rightHandDistance <= emit_value;
            end
        end
    end

    logic       pend_left, pend_right;
    logic [7:0] gain_left, gain_right;
    logic       wr_left, wr_right;

    assign wr_left  = cfgWrite && !cfgSide;
    assign wr_right = cfgWrite && cfgSide;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_left           <= 1'b1;
            pend_right          <= 1'b1;
            gain_left           <= DEFAULT_GAIN;
            gain_right          <= DEFAULT_GAIN;
            acceptLeftHandGain  <= 1'b0;
            acceptRightHandGain <= 1'b0;
            leftHandGain        <= 8'd0;
            rightHandGain       <= 8'd0;
        end else begin
            acceptLeftHandGain  <= pend_left;
            acceptRightHandGain <= pend_right;
            if (pend_left) begin
                leftHandGain <= gain_left;
            end
            if (pend_right) begin
                rightHandGain <= gain_right;
            end
            pend_left  <= wr_left;
            pend_right <= wr_right;
            if (wr_left) begin
                gain_left <= cfgGain;
            end
            if (wr_right) begin
                gain_right <= cfgGain;
            end
        end
    end

endmodule

// File: tb/tb_hand_range_transmitter.sv
// Randomized bench for hand_range_transmitter with a timeline-style reference model.
module tb_hand_range_transmitter;

    localparam int TRIG = 4;
    localparam int TO   = 100;
    localparam int GAP  = 10;
    localparam int SH   = 2;

`ifdef HAND_RANGE_AVG2_EN
    localparam logic [15:0] EXP_STUCK = 16'h8005;
    localparam logic [15:0] EXP_SHORT = 16'h8000;
`else
    localparam logic [15:0] EXP_STUCK = 16'hFFFF;
    localparam logic [15:0] EXP_SHORT = 16'h0001;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        leftEcho = 1'b0;
    logic        rightEcho = 1'b0;
    logic        cfgWrite = 1'b0;
    logic        cfgSide = 1'b0;
    logic [7:0]  cfgGain = 8'd0;
    logic        leftTrig, rightTrig;
    logic        acceptLeftHandDistance, acceptRightHandDistance;
    logic [15:0] leftHandDistance, rightHandDistance;
    logic        acceptLeftHandGain, acceptRightHandGain;
    logic [7:0]  leftHandGain, rightHandGain;

    int total = 0;
    int bad = 0;
    bit stop = 0;

    hand_range_transmitter #(
        .TRIG_CYCLES (TRIG),
        .ECHO_TIMEOUT(TO),
        .GAP_CYCLES  (GAP),
        .DIST_SHIFT  (SH),
        .DEFAULT_GAIN(8'h80)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .leftTrig               (leftTrig),
        .leftEcho               (leftEcho),
        .rightTrig              (rightTrig),
        .rightEcho              (rightEcho),
        .cfgWrite               (cfgWrite),
        .cfgSide                (cfgSide),
        .cfgGain                (cfgGain),
        .acceptLeftHandDistance (acceptLeftHandDistance),
        .leftHandDistance       (leftHandDistance),
        .acceptRightHandDistance(acceptRightHandDistance),
        .rightHandDistance      (rightHandDistance),
        .acceptLeftHandGain     (acceptLeftHandGain),
        .leftHandGain           (leftHandGain),
        .acceptRightHandGain    (acceptRightHandGain),
        .rightHandGain          (rightHandGain)
    );

    always #5 clk = ~clk;

    task automatic check16(input string nm, input logic [15:0] a, input logic [15:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic check1(input string nm, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Reference model: expected output values after each rising edge.
    logic        e_ltrig, e_rtrig, e_lacc, e_racc, e_lgacc, e_rgacc;
    logic [15:0] e_ldist, e_rdist;
    logic [7:0]  e_lgain, e_rgain;
`ifdef HAND_RANGE_AVG2_EN
    logic [15:0] hist [2];
`endif

    function automatic logic [15:0] conv(input int n);
        int v;
        if (n > TO) return 16'hFFFF;
        v = n >> SH;
        if (v == 0) v = 1;
        if (v > 65535) v = 65535;
        return 16'(v);
    endfunction

    function automatic logic echo_of(input int side);
        return (side != 0) ? rightEcho : leftEcho;
    endfunction

    function automatic logic trig_of(input int side);
        return (side != 0) ? rightTrig : leftTrig;
    endfunction

    task automatic tick(output bit ab);
        @(posedge clk);
        e_lacc = 1'b0;
        e_racc = 1'b0;
        ab = !reset;
    endtask

    task automatic set_trig(input int side, input logic v);
        if (side != 0) e_rtrig = v;
        else e_ltrig = v;
    endtask

    task automatic emit(input int side, input logic [15:0] res);
        logic [15:0] out;
        out = res;
`ifdef HAND_RANGE_AVG2_EN
        if (res != 0 && hist[side] != 0) out = 16'((32'(hist[side]) + 32'(res) + 1) >> 1);
        hist[side] = res;
`endif
        if (side != 0) begin
            e_racc  = 1'b1;
            e_rdist = out;
        end else begin
            e_lacc  = 1'b1;
            e_ldist = out;
        end
    endtask

    task automatic clear_model();
        e_ltrig = 0; e_rtrig = 0; e_lacc = 0; e_racc = 0;
        e_ldist = 0; e_rdist = 0;
`ifdef HAND_RANGE_AVG2_EN
        hist[0] = 0; hist[1] = 0;
`endif
    endtask

    task automatic run_model();
        bit ab;
        bit found;
        int side;
        int len;
        logic [15:0] res;
        side = 0;
        tick(ab); if (ab) return;
        forever begin
            for (int i = 0; i < TRIG; i++) begin
                tick(ab); if (ab) return;
                set_trig(side, 1'b1);
            end
            found = 0;
            for (int j = 1; j <= TO; j++) begin
                tick(ab); if (ab) return;
                set_trig(side, 1'b0);
                if (echo_of(side)) begin
                    found = 1;
                    break;
                end
            end
            res = 16'd0;
            if (found) begin
                len = 1;
                forever begin
                    tick(ab); if (ab) return;
                    if (!echo_of(side)) begin
                        res = conv(len);
                        break;
                    end
                    if (len == TO) begin
                        res = 16'hFFFF;
                        break;
                    end
                    len++;
                end
            end
            tick(ab); if (ab) return;
            emit(side, res);
            for (int i = 0; i < GAP; i++) begin
                tick(ab); if (ab) return;
            end
            side ^= 1;
        end
    endtask

    initial begin
        forever begin
            clear_model();
            @(posedge reset);
            run_model();
        end
    end

    // Gain expectation: strobe on the first edge after release, or one edge after a write.
    initial begin
        bit first, pw_l, pw_r;
        logic [7:0] pv_l, pv_r;
        first = 1; pw_l = 0; pw_r = 0; pv_l = 0; pv_r = 0;
        e_lgacc = 0; e_rgacc = 0; e_lgain = 0; e_rgain = 0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                first = 1; pw_l = 0; pw_r = 0;
                e_lgacc = 0; e_rgacc = 0; e_lgain = 0; e_rgain = 0;
            end else begin
                e_lgacc = first || pw_l;
                e_rgacc = first || pw_r;
                if (e_lgacc) e_lgain = pw_l ? pv_l : 8'h80;
                if (e_rgacc) e_rgain = pw_r ? pv_r : 8'h80;
                first = 0;
                pw_l = cfgWrite && !cfgSide;
                pw_r = cfgWrite && cfgSide;
                if (pw_l) pv_l = cfgGain;
                if (pw_r) pv_r = cfgGain;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check1("rst_ltrig", leftTrig, 1'b0);
                check1("rst_rtrig", rightTrig, 1'b0);
                check1("rst_ldacc", acceptLeftHandDistance, 1'b0);
                check1("rst_rdacc", acceptRightHandDistance, 1'b0);
                check16("rst_ldist", leftHandDistance, 16'd0);
                check16("rst_rdist", rightHandDistance, 16'd0);
                check1("rst_lgacc", acceptLeftHandGain, 1'b0);
                check1("rst_rgacc", acceptRightHandGain, 1'b0);
                check16("rst_lgain", 16'(leftHandGain), 16'd0);
                check16("rst_rgain", 16'(rightHandGain), 16'd0);
            end else begin
                check1("ltrig", leftTrig, e_ltrig);
                check1("rtrig", rightTrig, e_rtrig);
                check1("ldacc", acceptLeftHandDistance, e_lacc);
                check1("rdacc", acceptRightHandDistance, e_racc);
                check16("ldist", leftHandDistance, e_ldist);
                check16("rdist", rightHandDistance, e_rdist);
                check1("lgacc", acceptLeftHandGain, e_lgacc);
                check1("rgacc", acceptRightHandGain, e_rgacc);
                check16("lgain", 16'(leftHandGain), 16'(e_lgain));
                check16("rgain", 16'(rightHandGain), 16'(e_rgain));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_echo(input int side, input logic v);
        if (side != 0) rightEcho = v;
        else leftEcho = v;
    endtask

    task automatic drive_echo(input int side, input int d, input int len);
        cyc(d);
        if (len > 0) begin
            set_echo(side, 1'b1);
            cyc(len);
            set_echo(side, 1'b0);
        end
    endtask

    task automatic wait_trig(input int side);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (trig_of(side)) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                cyc(1);
                if (!trig_of(side)) begin
                    ok = 1;
                    break;
                end
            end
        end
        if (!ok) check1("trig_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_dacc(input int side, input int bound, output logic [15:0] val);
        bit seen;
        seen = 0;
        val = 16'd0;
        for (int i = 0; i < bound; i++) begin
            cyc(1);
            if ((side != 0) ? acceptRightHandDistance : acceptLeftHandDistance) begin
                seen = 1;
                val = (side != 0) ? rightHandDistance : leftHandDistance;
                break;
            end
        end
        if (!seen) check1("dacc_timeout", 1'b0, 1'b1);
    endtask

    task automatic release_and_check_start();
        reset = 1'b1;
        cyc(1);
        check1("start_lgacc", acceptLeftHandGain, 1'b1);
        check1("start_rgacc", acceptRightHandGain, 1'b1);
        check16("start_lgain", 16'(leftHandGain), 16'h0080);
        check16("start_rgain", 16'(rightHandGain), 16'h0080);
        check1("start_ltrig0", leftTrig, 1'b0);
        for (int k = 2; k <= 6; k++) begin
            cyc(1);
            check1("start_ltrig", leftTrig, (k <= 5) ? 1'b1 : 1'b0);
            check1("start_rtrig", rightTrig, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] v;
        int n;
        int s;
        cyc(3);
        release_and_check_start();

        drive_echo(0, 5, 40);
        wait_dacc(0, 10, v);
        check16("dist_40", v, 16'd10);
        check16("model_dist_40", e_ldist, 16'd10);

        n = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            n++;
            if (rightTrig) break;
        end
        check16("gap_len", 16'(n), 16'(GAP + 1));
        wait_trig(1);
        wait_dacc(1, 150, v);
        check16("dist_none", v, 16'd0);

        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (leftTrig) break;
        end
        check1("next_is_left", leftTrig, 1'b1);
        check1("right_idle", rightTrig, 1'b0);
        leftEcho = 1'b1;
        wait_dacc(0, 250, v);
        leftEcho = 1'b0;
        check16("dist_stuck", v, EXP_STUCK);

        wait_trig(1);
        drive_echo(1, $urandom_range(0, 50), $urandom_range(8, 60));
        wait_trig(0);
        drive_echo(0, 3, 2);
        cyc(1);
        cfgWrite = 1'b1;
        cfgSide = 1'b1;
        cfgGain = 8'h60;
        cyc(1);
        cfgWrite = 1'b0;
        check1("emit_ldacc", acceptLeftHandDistance, 1'b1);
        check16("dist_short", leftHandDistance, EXP_SHORT);
        check1("emit_rgacc0", acceptRightHandGain, 1'b0);
        cyc(1);
        check1("wr_rgacc", acceptRightHandGain, 1'b1);
        check16("wr_rgain", 16'(rightHandGain), 16'h0060);
        check1("emit_ldacc_off", acceptLeftHandDistance, 1'b0);

        s = 1;
        fork
            begin
                for (int m = 0; m < 14; m++) begin
                    wait_trig(s);
                    if ($urandom_range(0, 4) != 0)
                        drive_echo(s, $urandom_range(0, 90), $urandom_range(1, 105));
                    s ^= 1;
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    cyc(1);
                    cfgWrite = ($urandom_range(0, 3) == 0);
                    cfgSide = 1'($urandom_range(0, 1));
                    cfgGain = 8'($urandom);
                end
                cfgWrite = 1'b0;
            end
        join

        wait_trig(s);
        cyc(2);
        set_echo(s, 1'b1);
        cyc(10);
        reset = 1'b0;
        #1;
        check1("abort_ltrig", leftTrig, 1'b0);
        check1("abort_rdacc", acceptRightHandDistance, 1'b0);
        check1("abort_ldacc", acceptLeftHandDistance, 1'b0);
        check16("abort_rdist", rightHandDistance, 16'd0);
        check16("abort_ldist", leftHandDistance, 16'd0);
        check16("abort_lgain", 16'(leftHandGain), 16'd0);
        cyc(3);
        set_echo(s, 1'b0);
        release_and_check_start();
        drive_echo(0, 10, 24);
        wait_dacc(0, 10, v);
        check16("dist_after_reset", v, 16'd6);
        cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
